// File: rtl/umi_remap_cfg_if.sv
// UMI request/response channel pair seen by the remap configuration target.
// The master drives requests and consumes responses; the slave is the reverse.
interface umi_remap_cfg_if #(
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 256
);
    logic          req_valid;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;
    logic          req_ready;

    logic          resp_valid;
    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dstaddr;
    logic [AW-1:0] resp_srcaddr;
    logic [DW-1:0] resp_data;
    logic          resp_ready;

    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        input  req_ready,
        input  resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        output req_ready,
        output resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/umi_remap_cfg.sv
// UMI register target that holds the address-remap configuration and drives
// it as static vectors into the remap stage.
module umi_remap_cfg #(
    parameter int unsigned CW    = 32,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 256,
    parameter int unsigned IDW   = 16,
    parameter int unsigned NMAPS = 8,
    parameter int unsigned RAW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    umi_remap_cfg_if.slave       udev,
    output logic [IDW*NMAPS-1:0] old_row_col_address,
    output logic [IDW*NMAPS-1:0] new_row_col_address,
    output logic [AW-1:0]        set_dstaddress_offset,
    output logic [AW-1:0]        set_dstaddress_high,
    output logic [AW-1:0]        set_dstaddress_low
);
    localparam int unsigned HW = AW - 32;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;
    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_SLV    = 2'b10;

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state;
    logic [AW-1:0]  offset_q;
    logic [AW-1:0]  high_q;
    logic [AW-1:0]  low_q;
    logic [IDW-1:0] old_map [NMAPS];
    logic [IDW-1:0] new_map [NMAPS];

    logic [4:0]  opcode;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mapped;
    logic        legal;
    logic        accept;
    logic        is_rd;
    logic        is_wr;
    logic        is_po;
    logic        wr_en;
    logic        unused_bits;

    assign opcode = udev.req_cmd[4:0];
    assign size   = udev.req_cmd[7:5];
    assign len    = udev.req_cmd[15:8];
    assign off    = 32'(udev.req_dstaddr[RAW-1:0]);
    assign wdata  = udev.req_data[31:0];
    assign accept = udev.req_valid && udev.req_ready;
    assign is_rd  = (opcode == REQ_READ);
    assign is_wr  = (opcode == REQ_WRITE);
    assign is_po  = (opcode == REQ_POSTED);
    assign legal  = mapped && (size == 3'd2) && (len == 8'd0) && (off[1:0] == 2'b00);
    assign wr_en  = accept && (is_wr || is_po) && legal;

    assign unused_bits = ^{udev.req_cmd[CW-1:16], udev.req_dstaddr[AW-1:RAW], udev.req_data[DW-1:32]};

    // Address decode and read mux over the current register contents.
    always_comb begin
        mapped = 1'b0;
        rdata  = 32'h0;
        case (off)
            32'h00: begin mapped = 1'b1; rdata = offset_q[31:0]; end
            32'h04: begin mapped = 1'b1; rdata = 32'(offset_q[AW-1:32]); end
            32'h08: begin mapped = 1'b1; rdata = high_q[31:0]; end
            32'h0C: begin mapped = 1'b1; rdata = 32'(high_q[AW-1:32]); end
            32'h10: begin mapped = 1'b1; rdata = low_q[31:0]; end
            32'h14: begin mapped = 1'b1; rdata = 32'(low_q[AW-1:32]); end
            default: ;
        endcase
        for (int i = 0; i < int'(NMAPS); i++) begin
            if (off == 32'h20 + 32'(4 * i)) begin
                mapped = 1'b1;
                rdata  = {16'(new_map[i]), 16'(old_map[i])};
            end
        end
    end

    // Configuration registers; writes land at the acceptance edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            for (int i = 0; i < int'(NMAPS); i++) begin
                old_map[i] <= IDW'(i);
                new_map[i] <= IDW'(i);
            end
        end else if (wr_en) begin
            case (off)
                32'h00: offset_q[31:0]   <= wdata;
                32'h04: offset_q[AW-1:32] <= wdata[HW-1:0];
                32'h08: high_q[31:0]     <= wdata;
                32'h0C: high_q[AW-1:32]   <= wdata[HW-1:0];
                32'h10: low_q[31:0]      <= wdata;
                32'h14: low_q[AW-1:32]    <= wdata[HW-1:0];
                default: ;
            endcase
            for (int i = 0; i < int'(NMAPS); i++) begin
                if (off == 32'h20 + 32'(4 * i)) begin
                    old_map[i] <= wdata[IDW-1:0];
                    new_map[i] <= wdata[16 +: IDW];
                end
            end
        end
    end

    // Request/response FSM; the response buffer holds until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            udev.req_ready    <= 1'b1;
            udev.resp_valid   <= 1'b0;
            udev.resp_cmd     <= '0;
            udev.resp_dstaddr <= '0;
            udev.resp_srcaddr <= '0;
            udev.resp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (is_rd || is_wr)) begin
                        state             <= RESP;
                        udev.req_ready    <= 1'b0;
                        udev.resp_valid   <= 1'b1;
                        udev.resp_cmd     <= CW'({6'b0, (legal ? ERR_OK : ERR_SLV), 8'b0, len, size,
                                                  (is_rd ? RESP_READ : RESP_WRITE)});
                        udev.resp_dstaddr <= udev.req_srcaddr;
                        udev.resp_srcaddr <= udev.req_dstaddr;
                        udev.resp_data    <= DW'((legal && is_rd) ? rdata : 32'h0);
                    end
                end
                RESP: begin
                    if (udev.resp_ready) begin
                        state           <= IDLE;
                        udev.req_ready  <= 1'b1;
                        udev.resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign set_dstaddress_offset = offset_q;
    assign set_dstaddress_high   = high_q;
    assign set_dstaddress_low    = low_q;

    for (genvar g = 0; g < int'(NMAPS); g++) begin : g_map
        assign old_row_col_address[IDW*g +: IDW] = old_map[g];
        assign new_row_col_address[IDW*g +: IDW] = new_map[g];
    end
endmodule

// File: tb/tb_umi_remap_cfg.sv
// Directed self-checking bench for umi_remap_cfg: register access, posted
// writes, illegal accesses, backpressure and asynchronous reset.
module tb_umi_remap_cfg;
    localparam logic [4:0] OP_READ   = 5'h01;
    localparam logic [4:0] OP_WRITE  = 5'h03;
    localparam logic [4:0] OP_POSTED = 5'h05;

    logic         clk;
    logic         reset;
    logic [127:0] old_rc;
    logic [127:0] new_rc;
    logic [63:0]  offs;
    logic [63:0]  hi;
    logic [63:0]  lo;
    logic [127:0] ident;
    int           errors;
    int           checks;
    int           cyc;

    umi_remap_cfg_if #(.CW(32), .AW(64), .DW(256)) bus ();

    umi_remap_cfg #(
        .CW(32), .AW(64), .DW(256), .IDW(16), .NMAPS(8), .RAW(8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .udev                  (bus.slave),
        .old_row_col_address   (old_rc),
        .new_row_col_address   (new_rc),
        .set_dstaddress_offset (offs),
        .set_dstaddress_high   (hi),
        .set_dstaddress_low    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mkcmd(input logic [4:0] op, input logic [2:0] sz, input logic [7:0] ln);
        return {16'h0, ln, sz, op};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until the DUT accepts it.
    task automatic send(input logic [4:0] op, input logic [2:0] sz, input logic [7:0] ln,
                        input logic [63:0] addr, input logic [63:0] src, input logic [31:0] data,
                        output int n);
        logic rdy;
        bus.req_valid   = 1'b1;
        bus.req_cmd     = mkcmd(op, sz, ln);
        bus.req_dstaddr = addr;
        bus.req_srcaddr = src;
        bus.req_data    = 256'(data);
        n = 0;
        do begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        bus.req_valid = 1'b0;
        chk("send_accept", 256'(rdy), 256'(1));
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] ecmd, input logic [63:0] edst,
                               input logic [63:0] esrc, input logic [31:0] edata);
        chk({tag, "_valid"}, 256'(bus.resp_valid), 256'(1));
        chk({tag, "_cmd"},   256'(bus.resp_cmd), 256'(ecmd));
        chk({tag, "_dst"},   256'(bus.resp_dstaddr), 256'(edst));
        chk({tag, "_src"},   256'(bus.resp_srcaddr), 256'(esrc));
        chk({tag, "_data"},  bus.resp_data, 256'(edata));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk({tag, "_drop"},  256'(bus.resp_valid), 256'(0));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 8; i++) ident[16*i +: 16] = 16'(i);
        bus.req_valid   = 1'b0;
        bus.req_cmd     = '0;
        bus.req_dstaddr = '0;
        bus.req_srcaddr = '0;
        bus.req_data    = '0;
        bus.resp_ready  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_resp_valid", 256'(bus.resp_valid), 256'(0));
        chk("rst_req_ready",  256'(bus.req_ready), 256'(1));
        chk("rst_resp_cmd",   256'(bus.resp_cmd), 256'(0));
        chk("rst_offset",     256'(offs), 256'(0));
        chk("rst_high",       256'(hi), 256'(0));
        chk("rst_low",        256'(lo), 256'(0));
        chk("rst_old_map",    256'(old_rc), 256'(ident));
        chk("rst_new_map",    256'(new_rc), 256'(ident));
        chk("rst_new_entry1", 256'(new_rc[31:16]), 256'(16'h0001));

        send(OP_READ, 3'd2, 8'd0, 64'h24, 64'h1000, 32'h0, cyc);
        expect_resp("rd24", 32'h0000_0042, 64'h1000, 64'h24, 32'h0001_0001);

        // Posted writes: no response, one per cycle
        send(OP_POSTED, 3'd2, 8'd0, 64'h2C, 64'h0, 32'hFFF8_0003, cyc);
        chk("pw_new3",       256'(new_rc[63:48]), 256'(16'hFFF8));
        chk("pw_old3",       256'(old_rc[63:48]), 256'(16'h0003));
        chk("pw_no_resp",    256'(bus.resp_valid), 256'(0));
        chk("pw_ready",      256'(bus.req_ready), 256'(1));
        send(OP_POSTED, 3'd2, 8'd0, 64'h30, 64'h0, 32'h0044_0044, cyc);
        chk("pw_b2b_cyc1",   256'(cyc), 256'(1));
        send(OP_POSTED, 3'd2, 8'd0, 64'h34, 64'h0, 32'h0055_0066, cyc);
        chk("pw_b2b_cyc2",   256'(cyc), 256'(1));
        chk("pw_old4",       256'(old_rc[79:64]), 256'(16'h0044));
        chk("pw_new5",       256'(new_rc[95:80]), 256'(16'h0055));
        chk("pw_old5",       256'(old_rc[95:80]), 256'(16'h0066));
        chk("pw_no_resp2",   256'(bus.resp_valid), 256'(0));

        // Non-posted write then read-back
        send(OP_WRITE, 3'd2, 8'd0, 64'h04, 64'hABCD_0000, 32'h1234_5678, cyc);
        chk("wr04_offset",   256'(offs), 256'(64'h1234_5678_0000_0000));
        expect_resp("wr04", 32'h0000_0044, 64'hABCD_0000, 64'h04, 32'h0);
        send(OP_READ, 3'd2, 8'd0, 64'h04, 64'h2000, 32'h0, cyc);
        expect_resp("rd04", 32'h0000_0042, 64'h2000, 64'h04, 32'h1234_5678);

        // Illegal accesses
        send(OP_READ, 3'd2, 8'd0, 64'h80, 64'h2100, 32'h0, cyc);
        expect_resp("rd80", 32'h0200_0042, 64'h2100, 64'h80, 32'h0);
        send(OP_WRITE, 3'd3, 8'd0, 64'h00, 64'h2200, 32'hDEAD_BEEF, cyc);
        expect_resp("wr_sz3", 32'h0200_0064, 64'h2200, 64'h00, 32'h0);
        chk("wr_sz3_offset", 256'(offs), 256'(64'h1234_5678_0000_0000));
        send(OP_READ, 3'd2, 8'd0, 64'h22, 64'h2300, 32'h0, cyc);
        expect_resp("rd22", 32'h0200_0042, 64'h2300, 64'h22, 32'h0);
        send(OP_POSTED, 3'd2, 8'd1, 64'h10, 64'h0, 32'h0000_0005, cyc);
        chk("pw_len1_low",   256'(lo), 256'(0));
        chk("pw_len1_map",   256'(old_rc[15:0]), 256'(16'h0000));

        // Backpressure with a queued write
        send(OP_READ, 3'd2, 8'd0, 64'h2C, 64'h3000, 32'h0, cyc);
        bus.req_valid   = 1'b1;
        bus.req_cmd     = mkcmd(OP_WRITE, 3'd2, 8'd0);
        bus.req_dstaddr = 64'h08;
        bus.req_srcaddr = 64'h4000;
        bus.req_data    = 256'(32'h0000_0011);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 256'(bus.resp_valid), 256'(1));
            chk("bp_cmd",   256'(bus.resp_cmd), 256'(32'h0000_0042));
            chk("bp_data",  bus.resp_data, 256'(32'hFFF8_0003));
            chk("bp_ready", 256'(bus.req_ready), 256'(0));
        end
        chk("bp_high_held", 256'(hi), 256'(0));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("bp_drop",      256'(bus.resp_valid), 256'(0));
        chk("bp_ready_up",  256'(bus.req_ready), 256'(1));
        chk("bp_high_wait", 256'(hi), 256'(0));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_high_wr",   256'(hi), 256'(64'h11));
        expect_resp("bp_wr", 32'h0000_0044, 64'h4000, 64'h08, 32'h0);

        // Response ready while idle is ignored
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("idle_rr_valid", 256'(bus.resp_valid), 256'(0));
        chk("idle_rr_ready", 256'(bus.req_ready), 256'(1));

        // Asynchronous reset while a response is pending
        send(OP_READ, 3'd2, 8'd0, 64'h2C, 64'h5000, 32'h0, cyc);
        chk("ar_pending",   256'(bus.resp_valid), 256'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",     256'(bus.resp_valid), 256'(0));
        chk("ar_new3",      256'(new_rc[63:48]), 256'(16'h0003));
        chk("ar_old3",      256'(old_rc[63:48]), 256'(16'h0003));
        chk("ar_offset",    256'(offs), 256'(0));
        chk("ar_high",      256'(hi), 256'(0));
        chk("ar_req_ready", 256'(bus.req_ready), 256'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(OP_READ, 3'd2, 8'd0, 64'h2C, 64'h6000, 32'h0, cyc);
        expect_resp("post_rst", 32'h0000_0042, 64'h6000, 64'h2C, 32'h0003_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
